memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before an access is abandoned.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port resetN, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port inValid, input, 1, meaning an instruction is present from EX/MEM.
REQ-005 SHALL have ports memRead, memWrite, input, 1 each, the MEM control bits.
REQ-006 SHALL have port size, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have port loadUnsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have ports inALU (input, 32, address/result), inWriteData (input, 32), inRD (input, 5), inWB (input, 2: [1] regWrite, [0] memToReg).
REQ-009 SHALL have memory ports memReq, memWe, memAddr[31:0], memWdata[31:0], memByteEn[3:0] (outputs), plus memRdata[31:0] and memReady (inputs).
REQ-010 SHALL have outputs memoryWord[31:0], aluResult[31:0], rd[4:0], wb[1:0], which feed the MEM/WB register inputs.
REQ-011 SHALL have outputs stall (1), alignError (1), busError (1).

Function
REQ-012 SHALL implement the states IDLE, WAIT and DONE.
REQ-013 IDLE, inValid and neither memRead nor memWrite: stall=0; pass-through aluResult=inALU, rd=inRD, wb=inWB, memoryWord=0; no request.
REQ-014 IDLE, inValid, (memRead|memWrite), aligned: memReq=1 and stall=1 in the same cycle; next state WAIT.
REQ-015 Alignment: half requires inALU[0]=0; word requires inALU[1:0]=00.
REQ-016 A misaligned access SHALL issue no request, pulse alignError for 1 cycle, force wb=00, and keep stall=0.
REQ-017 memRead and memWrite both set SHALL be treated as a write.
REQ-018 WAIT: memReq=1; memAddr, memWe, memWdata and memByteEn held stable; stall=1 in every WAIT cycle, including the cycle in which memReady is seen.
REQ-019 memReady SHALL be sampled only in WAIT and ignored in IDLE and DONE.
REQ-020 WAIT with memReady=1: capture the formatted load data into an internal register; next state DONE; memReq drops in DONE.
REQ-021 DONE: stall=0; memoryWord equals the captured data (0 for stores); the pass-through fields are as in REQ-013; next state IDLE.
REQ-022 A load completes in (WAIT cycles + 2) cycles counted from the IDLE request cycle.
REQ-023 memAddr SHALL be {inALU[31:2],2'b00}.
REQ-024 Byte enables: byte -> 0001<<inALU[1:0]; half -> 0011<<inALU[1:0]; word -> 1111.
REQ-025 Store data SHALL be replicated: byte to all 4 lanes, half to both halves.
REQ-026 Load formatting: byte = lane inALU[1:0] of memRdata; half = lane inALU[1]; result extended per loadUnsigned.
REQ-027 A counter SHALL clear on WAIT entry and increment in each WAIT cycle without memReady.
REQ-028 When the counter reaches TIMEOUT: go to DONE, pulse busError for 1 cycle, and in DONE force wb=00 and memoryWord=0.
REQ-029 inValid=0 SHALL force wb=00 and start no access.
REQ-030 Upstream SHALL hold its inputs stable while stall=1; the block does not re-latch them.

Reset
REQ-031 resetN=0 SHALL immediately set state IDLE, counter 0, captured data 0, and memReq, memWe, memByteEn, alignError and busError to 0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the access with no DONE cycle; after release, operation resumes from IDLE.

Verification
REQ-033 Word load, addr 0x100, memReady after 3 WAIT cycles, memRdata 0xDEADBEEF -> stall high 4 cycles, then DONE with memoryWord 0xDEADBEEF, wb=inWB.
REQ-034 Byte load, addr 0x103, signed, memRdata 0x80FF_FF7F -> memoryWord 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Half store, addr 0x202, data 0x0000ABCD -> memByteEn 1100, memWdata 0xABCDABCD, memWe=1, memoryWord 0.
REQ-036 Word load at 0x101 -> alignError pulse, memReq stays 0, wb=00, stall=0.
REQ-037 TIMEOUT=4, memReady never asserted -> busError pulse after 4 WAIT cycles, wb=00, state returns to IDLE.
REQ-038 resetN low during the 2nd WAIT cycle -> memReq falls without waiting for a clock edge; a new load after release completes normally.

Source files
------------

// File: rtl/memory_stage.sv
// MEM pipeline stage: turns EX/MEM load/store requests into a held memory handshake,
// formats load data and produces the MEM/WB-facing fields plus stall/error flags.
module memory_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        inValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        loadUnsigned,
  input  logic [31:0] inALU,
  input  logic [31:0] inWriteData,
  input  logic [4:0]  inRD,
  input  logic [1:0]  inWB,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  output logic [31:0] memoryWord,
  output logic [31:0] aluResult,
  output logic [4:0]  rd,
  output logic [1:0]  wb,
  output logic        stall,
  output logic        alignError,
  output logic        busError,
  output logic [1:0]  dbgState
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          to_q, to_d;

  logic        access_w, is_load_w, aligned_w;
  logic [3:0]  byte_en_w;
  logic [31:0] wdata_w, load_fmt_w, cnt_inc_w;
  logic [7:0]  lane_b_w;
  logic [15:0] lane_h_w;
  logic        req_w, stall_w, align_err_w;
  logic [1:0]  wb_w;
  logic [31:0] mword_w;

  assign access_w  = inValid && (memRead || memWrite);
  assign is_load_w = memRead && !memWrite;
  assign cnt_inc_w = 32'(cnt_q) + 32'd1;

  always_comb begin
    aligned_w = 1'b1;
    byte_en_w = 4'b1111;
    wdata_w   = inWriteData;
    case (size)
      2'b00: begin
        byte_en_w = 4'b0001 << inALU[1:0];
        wdata_w   = {4{inWriteData[7:0]}};
      end
      2'b01: begin
        aligned_w = !inALU[0];
        byte_en_w = 4'b0011 << inALU[1:0];
        wdata_w   = {2{inWriteData[15:0]}};
      end
      default: aligned_w = (inALU[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    lane_b_w = memRdata[7:0];
    case (inALU[1:0])
      2'd1:    lane_b_w = memRdata[15:8];
      2'd2:    lane_b_w = memRdata[23:16];
      2'd3:    lane_b_w = memRdata[31:24];
      default: lane_b_w = memRdata[7:0];
    endcase
    lane_h_w = inALU[1] ? memRdata[31:16] : memRdata[15:0];
    case (size)
      2'b00:   load_fmt_w = loadUnsigned ? {24'd0, lane_b_w} : {{24{lane_b_w[7]}}, lane_b_w};
      2'b01:   load_fmt_w = loadUnsigned ? {16'd0, lane_h_w} : {{16{lane_h_w[15]}}, lane_h_w};
      default: load_fmt_w = memRdata;
    endcase
  end

  // Handshake: memReq rises with a request and stays high with address/data/enables held
  // until the cycle memReady is sampled high (or the wait budget runs out); memReady is
  // only meaningful while memReq is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    to_d        = to_q;
    req_w       = 1'b0;
    stall_w     = 1'b0;
    align_err_w = 1'b0;
    wb_w        = inValid ? inWB : 2'b00;
    mword_w     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (access_w) begin
          if (aligned_w) begin
            req_w   = 1'b1;
            stall_w = 1'b1;
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = S_WAIT;
          end else begin
            align_err_w = 1'b1;
            wb_w        = 2'b00;
          end
        end
      end
      S_WAIT: begin
        req_w   = 1'b1;
        stall_w = 1'b1;
        if (memReady) begin
          rdata_d = is_load_w ? load_fmt_w : 32'd0;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc_w[CW-1:0];
          if (cnt_inc_w == 32'(TIMEOUT)) begin
            rdata_d = 32'd0;
            to_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        mword_w = to_q ? 32'd0 : rdata_q;
        if (to_q) wb_w = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // Reset gates the combinational request path so it drops without waiting for an edge.
  assign memReq     = resetN && req_w;
  assign memWe      = memReq && memWrite;
  assign memByteEn  = memReq ? byte_en_w : 4'b0000;
  assign memAddr    = {inALU[31:2], 2'b00};
  assign memWdata   = wdata_w;
  assign alignError = resetN && align_err_w;
  assign busError   = (state_q == S_DONE) && to_q;
  assign stall      = stall_w;
  assign memoryWord = mword_w;
  assign aluResult  = inALU;
  assign rd         = inRD;
  assign wb         = wb_w;
  assign dbgState   = state_q;

endmodule
